conv33_window: RTL and testbench
================================

CONV33_WINDOW -- requirements
Module: conv33_window

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, signed pixel width.
REQ-002 The block SHALL expose parameter IMG_W, default 28, pixels per row, range 3..1024.
REQ-003 The block SHALL expose parameter IMG_H, default 28, rows per frame, range 3..1024.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port pix_in, input signed, DATA_WIDTH, raster-order pixel.
REQ-007 The block SHALL have port pix_valid, input, 1, pix_in accepted this cycle.
REQ-008 The block SHALL have ports data_0_0..data_2_2, output reg signed, DATA_WIDTH each, 3x3 window; row index first, row 0 oldest, column 2 newest.
REQ-009 The block SHALL have port conv33_en, output reg, 1, window valid; it drives the downstream conv33 enable.
REQ-010 The block SHALL have port frame_done, output reg, 1, one-cycle pulse after the last pixel of a frame.

Function
REQ-011 The block SHALL have no backpressure; every cycle with pix_valid=1 SHALL accept one pixel, and idle cycles SHALL not change any state.
REQ-012 Counters col (0..IMG_W-1) and row (0..IMG_H-1) SHALL advance per accepted pixel: col wraps to 0 and row increments at col=IMG_W-1; row wraps to 0 at the last pixel of a frame.
REQ-013 Two line buffers, each IMG_W deep, SHALL hold rows r-1 and r-2; each accepted pixel SHALL shift pix_in into buffer 1 and buffer 1's output into buffer 2.
REQ-014 On each accepted pixel, every window row SHALL shift left (x_0<=x_1, x_1<=x_2); data_2_2<=pix_in, data_1_2<=row r-1 at col, data_0_2<=row r-2 at col.
REQ-015 conv33_en SHALL be 1 in the cycle after accepting a pixel with row>=2 and col>=2, and 0 otherwise; output is valid (unpadded) convolution, (IMG_W-2)x(IMG_H-2) windows per frame.
REQ-016 Windows SHALL never straddle rows; windows with col<2 SHALL NOT assert conv33_en, even though stale columns are shifted in.
REQ-017 Window outputs SHALL hold their values while pix_valid=0.
REQ-018 frame_done SHALL pulse in the cycle after accepting pixel (IMG_H-1, IMG_W-1), coincident with the final conv33_en.
REQ-019 Back-to-back frames SHALL need no idle cycles; after a wrap, row 0/1 pixels of the new frame SHALL NOT produce conv33_en.
REQ-020 Pixel values SHALL pass through unmodified; signed extremes (-128, 127 at width 8) SHALL be preserved bit-exact.

Reset
REQ-021 rst=0 SHALL asynchronously clear col, row, all window outputs, conv33_en and frame_done to 0.
REQ-022 Line-buffer contents SHALL NOT need reset; counters guarantee that stale data never reaches an asserted window.
REQ-023 Reset mid-frame SHALL abort the frame; the first pixel after release SHALL be treated as (0,0).

Structure
REQ-024 Shared package conv_pkg SHALL hold DATA_WIDTH, IMG_W and IMG_H defaults, shared with the conv33 calc stage.
REQ-025 One sub-module, line_buffer (parameters DEPTH, WIDTH; ports clk, en, din, dout; a DEPTH-cycle delay per en), SHALL be instantiated twice.
REQ-026 Counter and control logic SHALL be a single always block; no FSM beyond the row/col counters is required.

Verification
REQ-027 5x5 frame, pixel = 5r+c, pix_valid continuous -> first conv33_en one cycle after pixel 12, window 0,1,2/5,6,7/10,11,12; exactly 9 conv33_en pulses; frame_done with the last pulse, window 12,13,14/17,18,19/22,23,24.
REQ-028 Same frame with pix_valid toggled 1,0,1,0 -> identical window sequence; outputs stable during gaps.
REQ-029 Two 5x5 frames back-to-back -> 18 conv33_en pulses; no pulse during the first 12 pixels of frame 2; 2 frame_done pulses.
REQ-030 rst=0 asserted after pixel 17, then the frame is restarted -> outputs 0 immediately (asynchronous); the restarted frame yields exactly 9 correct windows.
REQ-031 Frame of alternating -128/127 -> window values bit-exact, sign preserved at every position.

Source files
------------

// File: rtl/conv_pkg.sv
// ============================================================================
//  Module   : conv_pkg
//  Brief    : Shared defaults and helpers for the 3x3 convolution pipeline
//             (window generator and conv33 calc stage).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    // Default signed pixel width
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Default frame geometry (pixels per row, rows per frame)
    localparam int DEFAULT_IMG_W = 28;
    localparam int DEFAULT_IMG_H = 28;

    // Window is 3x3: the first two rows/columns of a frame only prime it
    localparam int WIN_SIZE = 3;
    localparam int WIN_LEAD = WIN_SIZE - 1;

    // Width of a counter spanning 0..n-1; never narrower than one bit
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : conv_pkg

`default_nettype wire

// File: rtl/line_buffer.sv
// ============================================================================
//  Module   : line_buffer
//  Brief    : Enable-gated delay line. Each cycle with en=1 shifts din in;
//             dout is the value written DEPTH enabled cycles earlier.
//             Contents are not reset: the window counters keep stale data
//             away from any asserted window.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module line_buffer #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Head of the delay line takes the incoming pixel
    always_ff @(posedge clk) begin
        if (en) begin
            taps[0] <= din;
        end
    end

    // Remaining stages each take the previous stage's value
    generate
        if (DEPTH > 1) begin : g_chain
            for (genvar i = 1; i < DEPTH; i++) begin : g_tap
                // Shift one stage further along on every enabled cycle
                always_ff @(posedge clk) begin
                    if (en) begin
                        taps[i] <= taps[i-1];
                    end
                end
            end
        end
    endgenerate

    assign dout = taps[DEPTH-1];

endmodule : line_buffer

`default_nettype wire

// File: rtl/conv33_window.sv
// ============================================================================
//  Module   : conv33_window
//  Brief    : Raster-order 3x3 sliding-window generator. Two line buffers
//             supply the two previous rows; a 3x3 register array shifts one
//             column per accepted pixel. conv33_en flags fully-populated,
//             non-straddling windows (valid convolution, no padding).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv33_window
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_W      = DEFAULT_IMG_W,
    parameter int IMG_H      = DEFAULT_IMG_H
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] pix_in,
    input  logic                         pix_valid,
    output logic signed [DATA_WIDTH-1:0] data_0_0,
    output logic signed [DATA_WIDTH-1:0] data_0_1,
    output logic signed [DATA_WIDTH-1:0] data_0_2,
    output logic signed [DATA_WIDTH-1:0] data_1_0,
    output logic signed [DATA_WIDTH-1:0] data_1_1,
    output logic signed [DATA_WIDTH-1:0] data_1_2,
    output logic signed [DATA_WIDTH-1:0] data_2_0,
    output logic signed [DATA_WIDTH-1:0] data_2_1,
    output logic signed [DATA_WIDTH-1:0] data_2_2,
    output logic                         conv33_en,
    output logic                         frame_done
);

    localparam int COL_W = cnt_width(IMG_W);
    localparam int ROW_W = cnt_width(IMG_H);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(WIN_LEAD);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(WIN_LEAD);

    // Position of the pixel about to be accepted
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Same column of the previous row (r-1) and the one before (r-2)
    logic [DATA_WIDTH-1:0] prev1_pix;
    logic [DATA_WIDTH-1:0] prev2_pix;

    logic col_at_end;
    logic row_at_end;
    logic win_complete;

    assign col_at_end   = (col == COL_LAST);
    assign row_at_end   = (row == ROW_LAST);
    // Window ending at this pixel lies entirely inside the current three
    // rows; smaller col means stale columns from the previous row remain.
    assign win_complete = (row >= ROW_FIRST) && (col >= COL_FIRST);

    // Row r-1: delays the incoming stream by exactly one image row
    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_WIDTH)
    ) u_line_buf1 (
        .clk  (clk),
        .en   (pix_valid),
        .din  (pix_in),
        .dout (prev1_pix)
    );

    // Row r-2: delays the first buffer's output by a further row
    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_WIDTH)
    ) u_line_buf2 (
        .clk  (clk),
        .en   (pix_valid),
        .din  (prev1_pix),
        .dout (prev2_pix)
    );

    // Row/column tracking plus the registered window-valid and end-of-frame flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col        <= '0;
            row        <= '0;
            conv33_en  <= 1'b0;
            frame_done <= 1'b0;
        end else if (pix_valid) begin
            conv33_en  <= win_complete;
            frame_done <= col_at_end && row_at_end;
            if (col_at_end) begin
                col <= '0;
                row <= row_at_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else begin
            conv33_en  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

    // Window array: each row shifts left, newest column enters on the right
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_0_0 <= '0;
            data_0_1 <= '0;
            data_0_2 <= '0;
            data_1_0 <= '0;
            data_1_1 <= '0;
            data_1_2 <= '0;
            data_2_0 <= '0;
            data_2_1 <= '0;
            data_2_2 <= '0;
        end else if (pix_valid) begin
            data_0_0 <= data_0_1;
            data_0_1 <= data_0_2;
            data_0_2 <= prev2_pix;
            data_1_0 <= data_1_1;
            data_1_1 <= data_1_2;
            data_1_2 <= prev1_pix;
            data_2_0 <= data_2_1;
            data_2_1 <= data_2_2;
            data_2_2 <= pix_in;
        end
    end

endmodule : conv33_window

`default_nettype wire

// File: tb/tb_conv33_window.sv
// ============================================================================
//  Module   : tb_conv33_window
//  Brief    : Self-checking bench for conv33_window on a 5x5 frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv33_window;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 5;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] pix_in;
    logic                 pix_valid;
    logic signed [DW-1:0] data_0_0, data_0_1, data_0_2;
    logic signed [DW-1:0] data_1_0, data_1_1, data_1_2;
    logic signed [DW-1:0] data_2_0, data_2_1, data_2_2;
    logic                 conv33_en;
    logic                 frame_done;

    conv33_window #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .data_0_0   (data_0_0),
        .data_0_1   (data_0_1),
        .data_0_2   (data_0_2),
        .data_1_0   (data_1_0),
        .data_1_1   (data_1_1),
        .data_1_2   (data_1_2),
        .data_2_0   (data_2_0),
        .data_2_1   (data_2_1),
        .data_2_2   (data_2_2),
        .conv33_en  (conv33_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9*DW-1:0] win;
        bit              fd;
    } exp_t;

    typedef struct {
        int pattern;   // 0: 5r+c, 1: alternating -128/127, 2: random
        bit gaps;      // idle cycle after every pixel
        int nframes;
        int exp_en;
        int exp_fd;
    } scen_t;

    exp_t                 q[$];
    logic signed [DW-1:0] img [H][W];
    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int fd_cnt = 0;
    bit mon_on = 0;
    bit acc_q  = 0;
    bit have_snap = 0;
    logic [9*DW-1:0] snap;

    function automatic logic [9*DW-1:0] cur_win();
        return {data_0_0, data_0_1, data_0_2,
                data_1_0, data_1_1, data_1_2,
                data_2_0, data_2_1, data_2_2};
    endfunction

    task automatic chk(input string name, input logic [9*DW-1:0] act,
                       input logic [9*DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] pix_val(input int pattern, input int r,
                                                     input int c);
        logic [31:0] rnd;
        case (pattern)
            0:       return DW'(5 * r + c);
            1:       return (((r * W + c) % 2) == 1) ? 8'sd127 : -8'sd128;
            default: begin
                rnd = $urandom;
                return rnd[DW-1:0];
            end
        endcase
    endfunction

    // Record the pixel in the model image and queue the window it completes
    task automatic drive_pixel(input int r, input int c, input logic signed [DW-1:0] v);
        exp_t e;
        img[r][c] = v;
        if (r >= 2 && c >= 2) begin
            e.win = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                     img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                     img[r][c-2],   img[r][c-1],   img[r][c]};
            e.fd  = (r == H - 1) && (c == W - 1);
            q.push_back(e);
        end
        pix_in    = v;
        pix_valid = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic drive_frame(input int pattern, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pixel(r, c, pix_val(pattern, r, c));
                if (gaps) begin
                    pix_in = 8'sh55;   // junk on an idle cycle must be ignored
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic drain_and_check(input string tag, input int exp_en, input int exp_fd);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_en_count"}, 72'(en_cnt), 72'(exp_en));
        chk({tag, "_fd_count"}, 72'(fd_cnt), 72'(exp_fd));
        chk({tag, "_queue_left"}, 72'(q.size()), 72'(0));
        q.delete();
        en_cnt = 0;
        fd_cnt = 0;
    endtask

    // Note whether the DUT accepted a pixel at this edge
    always @(posedge clk) acc_q = pix_valid && rst;

    // Output monitor: scoreboard pop on every window, hold check on idle edges
    always @(negedge clk) begin
        exp_t e;
        logic [9*DW-1:0] cw;
        if (mon_on && rst) begin
            cw = cur_win();
            if (conv33_en) begin
                en_cnt++;
                if (frame_done) fd_cnt++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_en: actual=1 required=0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("window", cw, e.win);
                    chk("frame_done", 72'(frame_done), 72'(e.fd));
                end
            end else begin
                chk("fd_without_en", 72'(frame_done), 72'(0));
            end
            if (!acc_q && have_snap) begin
                chk("hold_window", cw, snap);
                chk("idle_en", 72'(conv33_en), 72'(0));
            end
            snap      = cw;
            have_snap = 1;
        end else begin
            have_snap = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        scen_t tbl[6];
        tbl[0] = '{pattern: 0, gaps: 0, nframes: 1, exp_en: 9,  exp_fd: 1};
        tbl[1] = '{pattern: 0, gaps: 1, nframes: 1, exp_en: 9,  exp_fd: 1};
        tbl[2] = '{pattern: 0, gaps: 0, nframes: 2, exp_en: 18, exp_fd: 2};
        tbl[3] = '{pattern: 1, gaps: 0, nframes: 1, exp_en: 9,  exp_fd: 1};
        tbl[4] = '{pattern: 1, gaps: 1, nframes: 1, exp_en: 9,  exp_fd: 1};
        tbl[5] = '{pattern: 2, gaps: 1, nframes: 2, exp_en: 18, exp_fd: 2};

        rst       = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        #3;
        chk("reset_window", cur_win(), '0);
        chk("reset_en", 72'(conv33_en), 72'(0));
        chk("reset_fd", 72'(frame_done), 72'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        mon_on = 1;

        // First window of the 5r+c frame arrives exactly one cycle after pixel 12
        for (int i = 0; i < 13; i++) begin
            drive_pixel(i / W, i % W, pix_val(0, i / W, i % W));
            if (i == 11) chk("no_en_before_px12", 72'(conv33_en), 72'(0));
        end
        chk("first_en_after_px12", 72'(conv33_en), 72'(1));
        chk("first_window", cur_win(), 72'h00_01_02_05_06_07_0a_0b_0c);
        for (int i = 13; i < W * H; i++) drive_pixel(i / W, i % W, pix_val(0, i / W, i % W));
        chk("last_window", cur_win(), 72'h0c_0d_0e_11_12_13_16_17_18);
        chk("last_fd", 72'(frame_done), 72'(1));
        drain_and_check("directed", 9, 1);

        // Scenario table
        for (int s = 0; s < 6; s++) begin
            for (int f = 0; f < tbl[s].nframes; f++) drive_frame(tbl[s].pattern, tbl[s].gaps);
            drain_and_check($sformatf("scen%0d", s), tbl[s].exp_en, tbl[s].exp_fd);
        end

        // Mid-frame reset after pixel 17, then a clean restart
        for (int i = 0; i < 18; i++) drive_pixel(i / W, i % W, pix_val(0, i / W, i % W));
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_window", cur_win(), '0);
        chk("async_rst_en", 72'(conv33_en), 72'(0));
        chk("async_rst_fd", 72'(frame_done), 72'(0));
        q.delete();
        en_cnt = 0;
        fd_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive_frame(0, 0);
        drain_and_check("restart", 9, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_conv33_window

`default_nettype wire
